// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update arbiter.
// Optional same-cycle bypass is controlled by BP_UPD_BYPASS_EN (see bp_update_arbiter).
package bp_pkg;

    // Width of the opaque metadata the predictor hands to fetch and gets back on update.
    localparam int BP_META_WIDTH = 24;

    // Width of the starvation counter; STARVE_MAX must fit in it (1..15).
    localparam int STARVE_W = 4;

    // One resolved branch as written into the predictor table.
    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              target;
        logic                     dir;
        logic                     miss;
        logic [BP_META_WIDTH-1:0] meta;
    } bp_update_t;

    // Occupancy counter width for a FIFO of the given depth (0..depth inclusive).
    function automatic int bp_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bp_update_arbiter_if.sv
// Bundle of execute-update, fetch-lookup and table-write signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline's view.
interface bp_update_arbiter_if
    import bp_pkg::*;
#(
    parameter int META_W = BP_META_WIDTH,
    parameter int DEPTH  = 4
) ();

    localparam int CNT_W = bp_cnt_w(DEPTH);

    // Execute-stage update source
    logic              ex_update;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_target;
    logic              ex_dir;
    logic              ex_miss;
    logic [META_W-1:0] ex_meta;
    logic              ex_ready;

    // Fetch-stage lookup
    logic              fetch_req;
    logic              fetch_gnt;
    logic              fetch_stall;

    // Predictor table write port
    logic              tbl_upd_valid;
    logic [31:0]       tbl_upd_pc;
    logic [31:0]       tbl_upd_target;
    logic              tbl_upd_dir;
    logic              tbl_upd_miss;
    logic [META_W-1:0] tbl_upd_meta;

    // Status
    logic [CNT_W-1:0]  occupancy;
    logic              overflow;

    modport slave (
        input  ex_update, ex_pc, ex_target, ex_dir, ex_miss, ex_meta, fetch_req,
        output ex_ready, fetch_gnt, fetch_stall,
        output tbl_upd_valid, tbl_upd_pc, tbl_upd_target, tbl_upd_dir, tbl_upd_miss, tbl_upd_meta,
        output occupancy, overflow
    );

    modport master (
        output ex_update, ex_pc, ex_target, ex_dir, ex_miss, ex_meta, fetch_req,
        input  ex_ready, fetch_gnt, fetch_stall,
        input  tbl_upd_valid, tbl_upd_pc, tbl_upd_target, tbl_upd_dir, tbl_upd_miss, tbl_upd_meta,
        input  occupancy, overflow
    );

endinterface

// File: rtl/bp_upd_fifo.sv
// Circular buffer of pending predictor updates. The head entry is visible
// combinationally so the arbiter can inspect its miss bit in the same cycle.
// Caller guarantees push only when !full_o and pop only when !empty_o.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  bp_update_t                 push_data_i,
    input  logic                       pop_i,
    output bp_update_t                 head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [bp_cnt_w(DEPTH)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = bp_cnt_w(DEPTH);

    bp_update_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [DEPTH-1:0] wr_en;

    // Per-entry write enable decoded from the tail pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_i && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    // Pointer and occupancy next state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset discards everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the table-write data outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) mem_q[i] <= push_data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/bp_update_arbiter.sv
// Arbitrates the predictor's single table port between fetch lookups and
// queued execute-stage updates. Mispredict updates at the head win at once,
// a full FIFO or an exhausted starvation budget forces a drain, otherwise
// fetch has priority. Define BP_UPD_BYPASS_EN to let an update reach the
// table in its arrival cycle when the FIFO is empty and fetch is idle.
module bp_update_arbiter
    import bp_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int META_W     = BP_META_WIDTH,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              reset,
    bp_update_arbiter_if.slave bus
);

    localparam int CNT_W = bp_cnt_w(DEPTH);

    bp_update_t            ex_entry;
    bp_update_t            head;
    bp_update_t            upd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  push;
    logic                  pop;
    logic                  upd_valid;
    logic                  fetch_gnt;
    logic                  bypass_take;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  overflow_q, overflow_d;

    assign ex_entry = '{pc:     bus.ex_pc,
                        target: bus.ex_target,
                        dir:    bus.ex_dir,
                        miss:   bus.ex_miss,
                        meta:   bus.ex_meta};

    // Port grant: exactly one of fetch or update owns the table each cycle.
    always_comb begin
        fetch_gnt   = 1'b0;
        upd_valid   = 1'b0;
        bypass_take = 1'b0;
        if (fifo_empty) begin
            fetch_gnt = bus.fetch_req;
`ifdef BP_UPD_BYPASS_EN
            if (bus.ex_update && !bus.fetch_req) begin
                upd_valid   = 1'b1;
                bypass_take = 1'b1;
            end
`endif
        end else if (head.miss) begin
            upd_valid = 1'b1;
        end else if (fifo_full || (starve_q == STARVE_W'(STARVE_MAX))) begin
            upd_valid = 1'b1;
        end else if (bus.fetch_req) begin
            fetch_gnt = 1'b1;
        end else begin
            upd_valid = 1'b1;
        end
    end

    // A bypassed update is written directly and never enters the FIFO.
    assign push = bus.ex_update && !fifo_full && !bypass_take;
    assign pop  = upd_valid && !fifo_empty;

`ifdef BP_UPD_BYPASS_EN
    assign upd_data = bypass_take ? ex_entry : head;
`else
    assign upd_data = head;
`endif

    bp_upd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i (ex_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Starvation counter and sticky overflow next state.
    always_comb begin
        starve_d   = starve_q;
        overflow_d = overflow_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (!upd_valid && (starve_q != STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        if (bus.ex_update && fifo_full) begin
            overflow_d = 1'b1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.ex_ready       = !fifo_full;
    assign bus.fetch_gnt      = fetch_gnt;
    assign bus.fetch_stall    = bus.fetch_req && !fetch_gnt;
    assign bus.tbl_upd_valid  = upd_valid;
    assign bus.tbl_upd_pc     = upd_data.pc;
    assign bus.tbl_upd_target = upd_data.target;
    assign bus.tbl_upd_dir    = upd_data.dir;
    assign bus.tbl_upd_miss   = upd_data.miss;
    assign bus.tbl_upd_meta   = upd_data.meta;
    assign bus.occupancy      = fifo_count;
    assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Directed bench for bp_update_arbiter: reset/idle, miss priority, starvation,
// fill/overflow, idle drain order and asynchronous reset mid-run.
module tb_bp_update_arbiter;
    import bp_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   exp_idx;
    logic [31:0] idle_pc [5];
    logic        idle_v  [5];

    bp_update_arbiter_if #(.META_W(BP_META_WIDTH), .DEPTH(4)) bus ();

    bp_update_arbiter #(
        .DEPTH      (4),
        .META_W     (BP_META_WIDTH),
        .STARVE_MAX (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic miss);
        bus.ex_update = 1'b1;
        bus.ex_pc     = pc;
        bus.ex_target = pc + 32'h40;
        bus.ex_dir    = 1'b1;
        bus.ex_miss   = miss;
        bus.ex_meta   = pc[23:0];
        $display("push pc=0x%08h miss=%0b t=%0t", pc, miss, $time);
    endtask

    task automatic clear_upd();
        bus.ex_update = 1'b0;
        bus.ex_pc     = '0;
        bus.ex_target = '0;
        bus.ex_dir    = 1'b0;
        bus.ex_miss   = 1'b0;
        bus.ex_meta   = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef BP_UPD_BYPASS_EN
        idle_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        idle_pc = '{32'hA0, 32'hA4, 32'hA8, 32'h0, 32'h0};
`else
        idle_v  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        idle_pc = '{32'h0, 32'hA0, 32'hA4, 32'hA8, 32'h0};
`endif
        reset = 1'b0;
        clear_upd();
        bus.fetch_req = 1'b1;
        #1;
        // Reset values
        chk("rst_ex_ready",    bus.ex_ready, 1);
        chk("rst_fetch_gnt",   bus.fetch_gnt, 1);
        chk("rst_fetch_stall", bus.fetch_stall, 0);
        chk("rst_upd_valid",   bus.tbl_upd_valid, 0);
        chk("rst_upd_pc",      bus.tbl_upd_pc, 0);
        chk("rst_upd_meta",    bus.tbl_upd_meta, 0);
        chk("rst_occupancy",   bus.occupancy, 0);
        chk("rst_overflow",    bus.overflow, 0);

        @(negedge clk);
        reset = 1'b1;

        // Idle with fetch requesting every cycle
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_gnt", bus.fetch_gnt, 1);
            chk("idle_occ", bus.occupancy, 0);
            chk("idle_valid", bus.tbl_upd_valid, 0);
        end

        // Miss priority
        set_upd(32'h100, 1'b1);
        #1;
        chk("miss_push_ready", bus.ex_ready, 1);
        tick();
        clear_upd();
        #1;
        chk("miss_valid",  bus.tbl_upd_valid, 1);
        chk("miss_pc",     bus.tbl_upd_pc, 32'h100);
        chk("miss_target", bus.tbl_upd_target, 32'h140);
        chk("miss_flag",   bus.tbl_upd_miss, 1);
        chk("miss_stall",  bus.fetch_stall, 1);
        chk("miss_gnt",    bus.fetch_gnt, 0);
        tick();
        chk("miss_occ_after", bus.occupancy, 0);
        chk("miss_gnt_after", bus.fetch_gnt, 1);

        // Starvation: written exactly 8 cycles after the push
        set_upd(32'h200, 1'b0);
        tick();
        clear_upd();
        #1;
        for (int k = 1; k <= 7; k++) begin
            chk("starve_gnt",   bus.fetch_gnt, 1);
            chk("starve_valid", bus.tbl_upd_valid, 0);
            tick();
        end
        chk("starve_write_valid", bus.tbl_upd_valid, 1);
        chk("starve_write_pc",    bus.tbl_upd_pc, 32'h200);
        chk("starve_write_stall", bus.fetch_stall, 1);
        tick();
        chk("starve_occ_after", bus.occupancy, 0);

        // Fill and overflow with fetch requesting
        for (int i = 0; i < 5; i++) begin
            set_upd(32'h10 + 32'(4 * i), 1'b0);
            #1;
            if (i < 4) begin
                chk("fill_ready", bus.ex_ready, 1);
            end else begin
                chk("full_ready", bus.ex_ready, 0);
                chk("full_valid", bus.tbl_upd_valid, 1);
                chk("full_pc",    bus.tbl_upd_pc, 32'h10);
                chk("full_gnt",   bus.fetch_gnt, 0);
            end
            tick();
        end
        clear_upd();
        #1;
        chk("ovf_set", bus.overflow, 1);
        chk("ovf_occ", bus.occupancy, 3);
        exp_idx = 1;
        for (int c = 0; c < 40 && exp_idx < 4; c++) begin
            if (bus.tbl_upd_valid) begin
                chk("drain_pc", bus.tbl_upd_pc, 32'h10 + 32'(4 * exp_idx));
                $display("write pc=0x%08h t=%0t", bus.tbl_upd_pc, $time);
                exp_idx++;
            end
            tick();
        end
        chk("drain_count", 64'(exp_idx), 4);
        chk("drain_occ",   bus.occupancy, 0);
        chk("ovf_sticky",  bus.overflow, 1);

        // Idle drain order with fetch quiet
        bus.fetch_req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) set_upd(32'hA0 + 32'(4 * c), 1'b0);
            else       clear_upd();
            #1;
            chk("idle_drain_valid", bus.tbl_upd_valid, idle_v[c]);
            if (idle_v[c]) chk("idle_drain_pc", bus.tbl_upd_pc, idle_pc[c]);
            chk("idle_drain_gnt", bus.fetch_gnt, 0);
            tick();
        end
        chk("idle_drain_occ", bus.occupancy, 0);

        // Asynchronous reset with three entries queued
        bus.fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_upd(32'hB0 + 32'(4 * i), 1'b0);
            tick();
        end
        clear_upd();
        #1;
        chk("arst_pre_occ", bus.occupancy, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_occ",      bus.occupancy, 0);
        chk("arst_valid",    bus.tbl_upd_valid, 0);
        chk("arst_pc",       bus.tbl_upd_pc, 0);
        chk("arst_overflow", bus.overflow, 0);
        chk("arst_ready",    bus.ex_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        bus.fetch_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("arst_no_stale", bus.tbl_upd_valid, 0);
        end
        chk("arst_occ_end", bus.occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
